// File: rtl/aclk_lcd_pkg.sv
// rtl/aclk_lcd_pkg.sv - character constants, source-select and FSM encodings for the LCD scan driver
package aclk_lcd_pkg;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] ONE   = 8'h31;
  localparam logic [7:0] TWO   = 8'h32;
  localparam logic [7:0] THREE = 8'h33;
  localparam logic [7:0] FOUR  = 8'h34;
  localparam logic [7:0] FIVE  = 8'h35;
  localparam logic [7:0] SIX   = 8'h36;
  localparam logic [7:0] SEVEN = 8'h37;
  localparam logic [7:0] EIGHT = 8'h38;
  localparam logic [7:0] NINE  = 8'h39;
  localparam logic [7:0] ERROR = 8'h3A;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {
    CURRENT = 2'd0,
    KEY     = 2'd1,
    ALARM   = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/aclk_bcd_to_lcd.sv
// rtl/aclk_bcd_to_lcd.sv - combinational BCD nibble to ASCII character decoder
module aclk_bcd_to_lcd
  import aclk_lcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ERROR;
    case (bcd)
      4'd0:    ascii = ZERO;
      4'd1:    ascii = ONE;
      4'd2:    ascii = TWO;
      4'd3:    ascii = THREE;
      4'd4:    ascii = FOUR;
      4'd5:    ascii = FIVE;
      4'd6:    ascii = SIX;
      4'd7:    ascii = SEVEN;
      4'd8:    ascii = EIGHT;
      4'd9:    ascii = NINE;
      default: ascii = ERROR;
    endcase
  end

endmodule

// File: rtl/aclk_lcd_scan_driver.sv
// rtl/aclk_lcd_scan_driver.sv - snapshots a BCD time source per frame and streams it as ASCII, plus alarm latch
// Optional ACLK_LCD_BLINK_EN: blanks KEY/ALARM frames on a BLINK_FRAMES blink cadence.
module aclk_lcd_scan_driver
  import aclk_lcd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] current_time,
  input  logic [4*NUM_DIGITS-1:0] key_time,
  input  logic [4*NUM_DIGITS-1:0] alarm_time,
  input  logic                    show_alarm,
  input  logic                    show_new_time,
  input  logic                    alarm_enable,
  input  logic                    stop_alarm,
  input  logic                    lcd_ready,
  output logic [7:0]              lcd_data,
  output logic                    lcd_valid,
  output logic [2:0]              lcd_digit,
  output logic                    lcd_frame_start,
  output logic                    sound_alarm
);

  localparam logic [2:0] TOP_IDX  = 3'(NUM_DIGITS - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS must be within 1..8");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("GAP_CYCLES must be within 1..255");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("BLINK_FRAMES must be at least 1");
  end

  state_e                  state, state_nxt;
  src_e                    last_src, src_sel;
  logic [4*NUM_DIGITS-1:0] shadow, src_value;
  logic [2:0]              idx;
  logic [7:0]              gap_cnt;
  logic                    gap_done;
  logic [3:0]              cur_digit;
  logic [7:0]              dec_char;
  logic                    blank_frame;
  logic                    match, match_q;

  // Select 11 keeps showing whatever source the previous frame used.
  always_comb begin
    src_sel = last_src;
    case ({show_alarm, show_new_time})
      2'b00:   src_sel = CURRENT;
      2'b01:   src_sel = KEY;
      2'b10:   src_sel = ALARM;
      default: src_sel = last_src;
    endcase
  end

  always_comb begin
    src_value = alarm_time;
    case (src_sel)
      CURRENT: src_value = current_time;
      KEY:     src_value = key_time;
      default: src_value = alarm_time;
    endcase
  end

  assign gap_done = (gap_cnt == GAP_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = SEND;
      SEND:    if (lcd_ready && idx == 3'd0) state_nxt = GAP;
      GAP:     if (gap_done) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow   <= '0;
      last_src <= CURRENT;
      idx      <= TOP_IDX;
      gap_cnt  <= '0;
    end else begin
      case (state)
        LOAD: begin
          shadow   <= src_value;
          last_src <= src_sel;
          idx      <= TOP_IDX;
          gap_cnt  <= '0;
        end
        SEND: if (lcd_ready && idx != 3'd0) idx <= idx - 3'd1;
        GAP:  gap_cnt <= gap_done ? 8'd0 : gap_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) cur_digit = shadow[4*i +: 4];
    end
  end

  aclk_bcd_to_lcd u_bcd_to_lcd (
    .bcd   (cur_digit),
    .ascii (dec_char)
  );

`ifdef ACLK_LCD_BLINK_EN
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);
  logic [15:0] frame_cnt;
  logic        phase_on;

  // The frame sees the phase from before this LOAD's toggle, giving BLINK_FRAMES frames per half-period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_cnt   <= '0;
      phase_on    <= 1'b1;
      blank_frame <= 1'b0;
    end else if (state == LOAD) begin
      blank_frame <= !phase_on && (src_sel != CURRENT);
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt <= '0;
        phase_on  <= !phase_on;
      end else begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
`else
  assign blank_frame = 1'b0;
`endif

  assign lcd_valid       = (state == SEND);
  assign lcd_digit       = idx;
  assign lcd_frame_start = lcd_valid && (idx == TOP_IDX);
  assign lcd_data        = blank_frame ? SPACE : dec_char;

  // Only a fresh rising edge of match arms the sound; a clear always wins.
  assign match = (current_time == alarm_time);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      match_q     <= 1'b0;
      sound_alarm <= 1'b0;
    end else begin
      match_q <= match;
      if (stop_alarm || !alarm_enable) sound_alarm <= 1'b0;
      else if (match && !match_q)      sound_alarm <= 1'b1;
    end
  end

endmodule

// File: doc/aclk_lcd_scan_driver.md
Name: aclk_lcd_scan_driver

Overview:
Parametrised multi-digit successor to the single-digit alarm-clock LCD decoder. It selects one of three NUM_DIGITS-wide BCD time sources (current, key entry, alarm) and snapshots it once per frame. The snapshot is streamed to the LCD controller one ASCII character per valid/ready handshake, most significant digit first. It also owns a latched, stoppable alarm-sound output. Sits between the alarm-clock core (counter, key register, alarm register) and the LCD interface.

Parameters:
NUM_DIGITS, 4, number of BCD digits per time value (legal range 1..8).
GAP_CYCLES, 4, idle cycles between the end of one frame and the next snapshot (legal range 1..255).
BLINK_FRAMES, 8, frames per blink half-period; used only when ACLK_LCD_BLINK_EN is defined.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
current_time  input  4*NUM_DIGITS  current time, BCD, digit NUM_DIGITS-1 in the MSBs.
key_time  input  4*NUM_DIGITS  key-entry buffer, BCD.
alarm_time  input  4*NUM_DIGITS  stored alarm time, BCD.
show_alarm  input  1  display-select bit 1.
show_new_time  input  1  display-select bit 0.
alarm_enable  input  1  arms the alarm comparator.
stop_alarm  input  1  clears sound_alarm.
lcd_ready  input  1  LCD controller accepts the current character.
lcd_data  output  8  ASCII character.
lcd_valid  output  1  lcd_data is valid.
lcd_digit  output  3  index of the digit on lcd_data (NUM_DIGITS-1 down to 0).
lcd_frame_start  output  1  high with the first character of each frame.
sound_alarm  output  1  alarm sounding.

Behaviour:
- Reset (async, active-low): lcd_data=8'h30, lcd_valid=0, lcd_digit=NUM_DIGITS-1, lcd_frame_start=0, sound_alarm=0. FSM goes to LOAD, the gap counter to 0, the last-source register to CURRENT, and the previous-match flag to 0.
- Source select: {show_alarm,show_new_time} 00=current, 01=key, 10=alarm. 11 reuses the last-source register. The register updates only in LOAD.
- FSM states: LOAD, SEND, GAP.
- LOAD (1 cycle): copy the selected source into the shadow register, set digit index to NUM_DIGITS-1, go to SEND. Inputs changing in mid-frame never affect the frame in progress.
- SEND: lcd_valid=1; lcd_data=decode(shadow digit); lcd_frame_start=1 only for index NUM_DIGITS-1.
  - While lcd_valid=1 and lcd_ready=0, lcd_data, lcd_digit and lcd_frame_start hold stable.
  - On valid and ready, the index decrements. After index 0 is accepted, lcd_valid drops the next cycle and the FSM goes to GAP.
- GAP: count GAP_CYCLES cycles with lcd_valid=0, then go to LOAD.
- Frame period with lcd_ready tied high: NUM_DIGITS+GAP_CYCLES+1 cycles.
- Decode: 0..9 map to 8'h30..8'h39. Nibbles 10..15 map to ERROR 8'h3A.
- Alarm:
  - match = (current_time == alarm_time), computed on the full width.
  - sound_alarm sets on the cycle after a 0-to-1 transition of match while alarm_enable=1.
  - It clears on the cycle after stop_alarm=1 or alarm_enable=0.
  - A set and a clear condition in the same cycle: the clear wins.
  - A match that persists after a stop does not retrigger; only a new rising edge of match does.
- A reset asserted mid-frame drops lcd_valid immediately. No partial handshake completes.

Optional Feature:
ACLK_LCD_BLINK_EN
- Defined: a frame counter toggles a blink phase every BLINK_FRAMES frames, counted at LOAD. While the latched source is KEY or ALARM and the phase is off, every character sent is SPACE 8'h20. Handshake and timing are unchanged. The phase resets to on.
- Not defined: no frame counter and no blank characters. BLINK_FRAMES is ignored.

Decomposition:
- Package aclk_lcd_pkg holds:
  - character constants ZERO..NINE (8'h30..8'h39), ERROR 8'h3A, SPACE 8'h20;
  - the source-select encoding CURRENT/KEY/ALARM;
  - the FSM state encoding LOAD/SEND/GAP.
- One sub-module, aclk_bcd_to_lcd: combinational 4-bit BCD to 8-bit ASCII decoder, instantiated once on the muxed shadow digit.

Test Plan:
- NUM_DIGITS=4, GAP_CYCLES=4, lcd_ready=1, mode 00, current_time=16'h1234 -> characters 31,32,33,34 on consecutive cycles with lcd_digit 3..0 and frame_start on 31; the next frame starts 9 cycles later.
- Backpressure: lcd_ready low for 3 cycles on the second character (8'h32) -> lcd_data and lcd_digit hold for 3 cycles, then the stream resumes with no lost or duplicated characters.
- Mode 01 with key_time=16'h0A59 -> 30,3A,35,39. Change key_time in mid-frame -> the current frame is unchanged and the next frame shows the new value. Mode 11 after mode 10 -> alarm_time is still shown.
- alarm_enable=1, alarm_time=16'h0700, current_time steps 0659 to 0700 -> sound_alarm high on the next cycle. Pulse stop_alarm while the times still match -> low next cycle and no retrigger. Stop and a new match edge in the same cycle -> stays low.
- Assert reset while in SEND at digit 2 -> all outputs return to reset values immediately. After release the first frame restarts at digit 3.
- ACLK_LCD_BLINK_EN, BLINK_FRAMES=2, mode 10 -> two frames of digits, two frames of 20,20,20,20, alternating. In mode 00 no blanking occurs.
